// File: rtl/cic_interp.sv
// Single-stage CIC interpolator: low-rate comb (delay 2^TC), zero-stuff, per-tick integrate, scale by 2^-TC.
// Build option: define CIC_INTERP_UNDERRUN_ZERO_EN to inject zero instead of repeating the last sample on underrun.
module cic_interp #(
  parameter int RATE       = 1024,
  parameter int LOG2RATE   = 10,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic [3:0]         TC,
  input  logic signed [31:0] IN,
  input  logic               in_valid,
  output logic               in_ready,
  output logic signed [31:0] OUT,
  output logic               out_valid,
  output logic               underrun,
  output logic               o_dbg_state
);

  typedef enum logic {S_FILL = 1'b0, S_RUN = 1'b1} state_t;

  localparam logic [LOG2RATE-1:0] LAST_TICK = LOG2RATE'(RATE - 1);
  localparam logic [3:0]          TC_MAX    = 4'(DEPTH_LOG2 - 1);

  state_t                  r_state, w_state_next;
  logic [DEPTH_LOG2-1:0]   r_fill, w_fill_next;
  logic [LOG2RATE-1:0]     r_tickcount;
  logic                    r_lasttick;
  logic                    r_buf_full;
  logic signed [31:0]      r_buf;
  logic signed [31:0]      r_last;
  logic [DEPTH_LOG2-1:0]   r_wptr;
  logic [3:0]              r_tc;
  logic                    r_tc_vld;
  logic signed [32:0]      r_comb;
  logic signed [48:0]      r_integ;
  logic                    r_ev_d;
  logic                    r_underrun;
  logic signed [31:0]      r_out;
  logic                    r_out_valid;
  logic signed [31:0]      r_hist [2**DEPTH_LOG2];

  logic                    w_tick_ev, w_boundary, w_zstuff, w_transfer, w_restart;
  logic [3:0]              w_tc_clamp;
  logic [DEPTH_LOG2-1:0]   w_k;
  logic signed [31:0]      w_x, w_hist_rd;
  logic signed [32:0]      w_comb;

  assign w_tick_ev  = tick && !r_lasttick;
  assign w_boundary = w_tick_ev && (r_tickcount == '0);
  assign w_zstuff   = w_tick_ev && (r_tickcount == LOG2RATE'(1));
  assign w_transfer = in_valid && !r_buf_full;
  assign w_tc_clamp = (TC > TC_MAX) ? TC_MAX : TC;
  // The very first boundary after reset has no previous TC sample and always restarts the fill.
  assign w_restart  = w_boundary && (!r_tc_vld || (w_tc_clamp != r_tc));
  assign w_k        = DEPTH_LOG2'(1) << w_tc_clamp;
  assign w_hist_rd  = r_hist[r_wptr - w_k];

  always_comb begin
    w_x = r_buf;
    if (!r_buf_full) begin
`ifdef CIC_INTERP_UNDERRUN_ZERO_EN
      w_x = '0;
`else
      w_x = r_last;
`endif
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_fill_next  = r_fill;
    if (w_boundary) begin
      if (w_restart) begin
        w_state_next = S_FILL;
        w_fill_next  = '0;
      end else if (r_state == S_FILL) begin
        if (r_fill == (w_k - DEPTH_LOG2'(1))) w_state_next = S_RUN;
        else                                  w_fill_next  = r_fill + DEPTH_LOG2'(1);
      end
    end
  end

  // The comb subtracts history only once the window is full, i.e. from the boundary entering RUN.
  assign w_comb = {w_x[31], w_x} - ((w_state_next == S_RUN) ? {w_hist_rd[31], w_hist_rd} : 33'sd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_FILL;
      r_fill      <= '0;
      r_tickcount <= '0;
      r_lasttick  <= 1'b0;
      r_buf_full  <= 1'b0;
      r_buf       <= '0;
      r_last      <= '0;
      r_wptr      <= '0;
      r_tc        <= '0;
      r_tc_vld    <= 1'b0;
      r_comb      <= '0;
      r_integ     <= '0;
      r_ev_d      <= 1'b0;
      r_underrun  <= 1'b0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_fill     <= w_fill_next;
      r_lasttick <= tick;
      r_ev_d     <= w_tick_ev;
      if (w_tick_ev) r_tickcount <= (r_tickcount == LAST_TICK) ? '0 : r_tickcount + LOG2RATE'(1);
      if (w_transfer) begin
        r_buf      <= IN;
        r_buf_full <= 1'b1;
      end else if (w_boundary) begin
        r_buf_full <= 1'b0;
      end
      if (w_boundary) begin
        r_last   <= w_x;
        r_wptr   <= r_wptr + DEPTH_LOG2'(1);
        r_tc     <= w_tc_clamp;
        r_tc_vld <= 1'b1;
        r_comb   <= w_comb;
        if (!r_buf_full) r_underrun <= 1'b1;
      end
      if (w_restart)     r_integ <= '0;
      else if (w_zstuff) r_integ <= r_integ + {{16{r_comb[32]}}, r_comb};
      r_out_valid <= r_ev_d;
      if (r_ev_d) r_out <= 32'(r_integ >>> r_tc);
    end
  end

  always_ff @(posedge clk) begin
    if (w_boundary) r_hist[r_wptr] <= w_x;
  end

  assign in_ready    = !r_buf_full;
  assign OUT         = r_out;
  assign out_valid   = r_out_valid;
  assign underrun    = r_underrun;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_cic_interp.sv
// Bench for cic_interp at RATE=4: a moving-sum reference model feeds an expected-output queue.
module tb_cic_interp;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               tick = 1'b0;
  logic [3:0]         TC = 4'd2;
  logic signed [31:0] IN = '0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [31:0] OUT;
  logic               out_valid;
  logic               underrun;
  logic               o_dbg_state;

  int n_cmp = 0;
  int n_mis = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_v;

  // reference model state
  longint win_q[$];
  longint m_sum = 0;
  longint m_last = 0;
  int     m_tc = 0;
  bit     m_tc_vld = 0;
  bit     m_underrun = 0;

  cic_interp #(.RATE(4), .LOG2RATE(2), .DEPTH_LOG2(8)) dut (
    .clk(clk), .rst(rst), .tick(tick), .TC(TC), .IN(IN), .in_valid(in_valid),
    .in_ready(in_ready), .OUT(OUT), .out_valid(out_valid), .underrun(underrun),
    .o_dbg_state(o_dbg_state)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_mis++;
        $display("FAIL out_extra: got %0d, want no output", OUT);
      end else begin
        exp_v = exp_q.pop_front();
        if (OUT !== exp_v) begin
          n_mis++;
          $display("FAIL out_value: got %0d, want %0d", OUT, $signed(exp_v));
        end
      end
    end
  end

  function automatic logic [31:0] m_shift(input longint s, input int sh);
    longint t;
    t = s >>> sh;
    return t[31:0];
  endfunction

  task automatic model_reset();
    win_q.delete();
    m_sum = 0; m_last = 0; m_tc = 0; m_tc_vld = 0; m_underrun = 0;
  endtask

  task automatic send_sample(input logic signed [31:0] val);
    IN = val;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drive_tick();
    tick = 1'b1;
    repeat (2) @(posedge clk);
    #1 tick = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  // One frame: optional sample delivery, model update at the boundary, then RATE ticks.
  task automatic drive_frame(input bit send, input logic signed [31:0] val);
    int     tcc;
    bit     restart;
    longint x;
    if (send) send_sample(val);
    tcc = (int'(TC) > 7) ? 7 : int'(TC);
    restart = !m_tc_vld || (tcc != m_tc);
    if (send) x = longint'(val);
    else begin
      m_underrun = 1;
`ifdef CIC_INTERP_UNDERRUN_ZERO_EN
      x = 0;
`else
      x = m_last;
`endif
    end
    m_last = x;
    if (restart) begin
      m_tc = tcc; m_tc_vld = 1; win_q.delete(); m_sum = 0;
    end
    exp_q.push_back(m_shift(m_sum, m_tc));
    win_q.push_back(x);
    if (win_q.size() > (1 << m_tc)) void'(win_q.pop_front());
    m_sum = 0;
    foreach (win_q[i]) m_sum += win_q[i];
    repeat (3) exp_q.push_back(m_shift(m_sum, m_tc));
    repeat (4) drive_tick();
  endtask

  task automatic test_reset();
    n_cmp++;
    if (OUT !== 32'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || underrun !== 1'b0 || o_dbg_state !== 1'b0) begin
      n_mis++;
      $display("FAIL reset_values: got OUT=%0d ov=%b rdy=%b unr=%b st=%b, want 0 0 1 0 0",
               OUT, out_valid, in_ready, underrun, o_dbg_state);
    end
  endtask

  task automatic test_ramp(input string name);
    TC = 4'd2;
    repeat (6) drive_frame(1, 1000);
    n_cmp++;
    if (underrun !== m_underrun) begin
      n_mis++; $display("FAIL %s_underrun: got %b, want %b", name, underrun, m_underrun);
    end
    n_cmp++;
    if (o_dbg_state !== 1'b1) begin
      n_mis++; $display("FAIL %s_state: got %b, want 1", name, o_dbg_state);
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_mis++; $display("FAIL %s_drain: got %0d pending, want 0", name, exp_q.size());
    end
  endtask

  task automatic test_impulse();
    TC = 4'd1;
    repeat (3) drive_frame(1, 0);
    drive_frame(1, 4000);
    repeat (3) drive_frame(1, 0);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_mis++; $display("FAIL impulse_drain: got %0d pending, want 0", exp_q.size());
    end
  endtask

  task automatic test_negative();
    TC = 4'd3;
    repeat (10) drive_frame(1, -8);
    TC = 4'd1;
    repeat (4) drive_frame(1, -1);
    n_cmp++;
    if (OUT !== 32'hFFFF_FFFF) begin
      n_mis++; $display("FAIL negative_final: got %0d, want -1", OUT);
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_mis++; $display("FAIL negative_drain: got %0d pending, want 0", exp_q.size());
    end
  endtask

  task automatic test_clamp();
    TC = 4'd15;
    repeat (3) drive_frame(1, 256);
    for (int i = 0; i < 3; i++) drive_frame(1, $urandom_range(0, 2000));
    n_cmp++;
    if (o_dbg_state !== 1'b0) begin
      n_mis++; $display("FAIL clamp_state: got %b, want 0", o_dbg_state);
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_mis++; $display("FAIL clamp_drain: got %0d pending, want 0", exp_q.size());
    end
  endtask

  task automatic test_tc_switch();
    TC = 4'd2;
    repeat (6) drive_frame(1, 1000);
    TC = 4'd1;
    repeat (4) drive_frame(1, 1000);
    n_cmp++;
    if (OUT !== 32'd1000) begin
      n_mis++; $display("FAIL tc_switch_final: got %0d, want 1000", OUT);
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_mis++; $display("FAIL tc_switch_drain: got %0d pending, want 0", exp_q.size());
    end
  endtask

  task automatic test_underrun();
    TC = 4'd1;
    repeat (4) drive_frame(1, 500);
    n_cmp++;
    if (underrun !== 1'b0) begin
      n_mis++; $display("FAIL underrun_pre: got %b, want 0", underrun);
    end
    drive_frame(0, 0);
    n_cmp++;
    if (underrun !== 1'b1) begin
      n_mis++; $display("FAIL underrun_set: got %b, want 1", underrun);
    end
    repeat (3) drive_frame(1, 500);
    n_cmp++;
    if (underrun !== m_underrun) begin
      n_mis++; $display("FAIL underrun_sticky: got %b, want %b", underrun, m_underrun);
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_mis++; $display("FAIL underrun_drain: got %0d pending, want 0", exp_q.size());
    end
  endtask

  task automatic test_async_reset();
    send_sample(77);
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_mis++; $display("FAIL buf_full_ready: got %b, want 0", in_ready);
    end
    #3 rst = 1'b1;
    #1;
    n_cmp++;
    if (OUT !== 32'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || underrun !== 1'b0 || o_dbg_state !== 1'b0) begin
      n_mis++;
      $display("FAIL async_reset: got OUT=%0d ov=%b rdy=%b unr=%b st=%b, want 0 0 1 0 0",
               OUT, out_valid, in_ready, underrun, o_dbg_state);
    end
    exp_q.delete();
    model_reset();
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    test_ramp("restart");
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    test_ramp("ramp");
    test_impulse();
    test_negative();
    test_clamp();
    test_tc_switch();
    test_underrun();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
